// File: rtl/pl_pkg.sv
// Shared definitions for the pulse train generator.
//   pl_state_t : FSM encoding (IDLE, HIGH, LOW, DONE)
//   pl_cfg_t   : train parameters captured on a launch rise
//   MLT_*      : tick-rate select codes
//   low_len()  : low-phase length in ticks, clamped to at least one tick
package pl_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} pl_state_t;

  localparam int DIV_MID_DEFAULT  = 100;
  localparam int DIV_SLOW_DEFAULT = 100000;

  localparam logic [4:0] MLT_FAST = 5'd1;
  localparam logic [4:0] MLT_MID  = 5'd2;
  localparam logic [4:0] MLT_SLOW = 5'd3;

  typedef struct packed {
    logic [16:0] width;
    logic [16:0] period;
    logic [4:0]  mlt;
  } pl_cfg_t;

  // The difference can go negative, so it is taken one bit wider and signed.
  function automatic logic [16:0] low_len(input logic [16:0] width,
                                          input logic [16:0] period);
    logic signed [17:0] diff;
    diff = $signed({1'b0, period}) - $signed({1'b0, width});
    return (diff <= 18'sd0) ? 17'd1 : diff[16:0];
  endfunction

endpackage

// File: rtl/pl_tick_div.sv
// Tick prescaler: emits a one-clk tick enable every N clks, with N selected by
// mlt (MLT_MID -> DIV_MID, MLT_SLOW -> DIV_SLOW, anything else -> every clk).
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear; the next tick comes a full period later
//   mlt        : rate select
//   tick       : one-clk enable
module pl_tick_div
  import pl_pkg::*;
#(
  parameter int DIV_MID  = DIV_MID_DEFAULT,
  parameter int DIV_SLOW = DIV_SLOW_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic [4:0] mlt,
  output logic       tick
);

  localparam int CW = $clog2((DIV_SLOW > DIV_MID) ? DIV_SLOW : DIV_MID) + 1;

  logic [CW-1:0] cnt_q, cnt_d, last;

  always_comb begin
    case (mlt)
      MLT_MID:  last = CW'(DIV_MID - 1);
      MLT_SLOW: last = CW'(DIV_SLOW - 1);
      default:  last = '0;
    endcase
    // >= rather than == so a stale count can never run away past the terminal value
    tick  = !clr && (cnt_q >= last);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pulse_train_gen.sv
// Optical sync pulse train generator, triggered by the launch_PL level from
// the delay stage.
//   clk_PL, rst_n   : clock, async active-low reset
//   launch_PL       : async level; rise starts a train, low aborts / re-arms
//   pl_width        : pulse high time (ticks)
//   pl_period       : pulse-start spacing (ticks)
//   pl_count        : pulses per train
//   pl_mlt          : tick-rate select
//   PL_out          : pulse drive
//   busy_PL         : train in progress (through the End_PL clk)
//   End_PL          : one-clk strobe on the final falling edge
module pulse_train_gen
  import pl_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DIV_MID     = DIV_MID_DEFAULT,
  parameter int DIV_SLOW    = DIV_SLOW_DEFAULT
) (
  input  logic        clk_PL,
  input  logic        rst_n,
  input  logic        launch_PL,
  input  logic [16:0] pl_width,
  input  logic [16:0] pl_period,
  input  logic [7:0]  pl_count,
  input  logic [4:0]  pl_mlt,
  output logic        PL_out,
  output logic        busy_PL,
  output logic        End_PL
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  pl_cfg_t                cfg_q, cfg_d;
  logic                   launch_s;
  logic                   tick;

  pl_state_t   state_q;
  logic [16:0] ph_cnt_q;
  logic [7:0]  left_q;
  logic        pl_out_q, busy_q, end_q;

  assign launch_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, launch_PL});
    prev_d = launch_s;
    // Rise is registered so the FSM, prescaler clear and config latch all
    // act on the same clk.
    rise_d = launch_s & ~prev_q;
    cfg_d  = rise_q ? '{width: pl_width, period: pl_period, mlt: pl_mlt} : cfg_q;
  end

  always_ff @(posedge clk_PL or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      cfg_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      cfg_q  <= cfg_d;
    end
  end

  pl_tick_div #(
    .DIV_MID  (DIV_MID),
    .DIV_SLOW (DIV_SLOW)
  ) u_tick (
    .clk   (clk_PL),
    .rst_n (rst_n),
    .clr   (rise_q),
    .mlt   (cfg_q.mlt),
    .tick  (tick)
  );

  // Abort (synced launch low) is tested before the tick so it always wins.
  always_ff @(posedge clk_PL or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ph_cnt_q <= '0;
      left_q   <= '0;
      pl_out_q <= 1'b0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
    end else begin
      end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise_q) begin
            ph_cnt_q <= '0;
            left_q   <= pl_count;
            busy_q   <= 1'b1;
            if (pl_count != 8'd0 && pl_width != 17'd0) begin
              state_q  <= HIGH;
              pl_out_q <= 1'b1;
            end else begin
              state_q <= DONE;
              end_q   <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (!launch_s) begin
            state_q  <= IDLE;
            pl_out_q <= 1'b0;
            busy_q   <= 1'b0;
          end else if (tick) begin
            if (ph_cnt_q == cfg_q.width - 17'd1) begin
              ph_cnt_q <= '0;
              pl_out_q <= 1'b0;
              if (left_q > 8'd1) begin
                state_q <= LOW;
              end else begin
                state_q <= DONE;
                end_q   <= 1'b1;
              end
            end else begin
              ph_cnt_q <= ph_cnt_q + 17'd1;
            end
          end
        end
        LOW: begin
          if (!launch_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (ph_cnt_q == low_len(cfg_q.width, cfg_q.period) - 17'd1) begin
              ph_cnt_q <= '0;
              pl_out_q <= 1'b1;
              left_q   <= left_q - 8'd1;
              state_q  <= HIGH;
            end else begin
              ph_cnt_q <= ph_cnt_q + 17'd1;
            end
          end
        end
        DONE: begin
          // busy stays up through the End_PL clk, then drops; no re-trigger
          // until launch has been seen low.
          busy_q <= 1'b0;
          if (!launch_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PL_out  = pl_out_q;
  assign busy_PL = busy_q;
  assign End_PL  = end_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;
  localparam int S  = 2;
  localparam int DM = 100;
  localparam int DS = 250;

  logic        clk_PL = 1'b0;
  logic        rst_n = 1'b0;
  logic        launch_PL = 1'b0;
  logic [16:0] pl_width = '0;
  logic [16:0] pl_period = '0;
  logic [7:0]  pl_count = '0;
  logic [4:0]  pl_mlt = '0;
  logic        PL_out, busy_PL, End_PL;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_PL = ~clk_PL;

  pulse_train_gen #(.SYNC_STAGES(S), .DIV_MID(DM), .DIV_SLOW(DS)) dut (
    .clk_PL    (clk_PL),
    .rst_n     (rst_n),
    .launch_PL (launch_PL),
    .pl_width  (pl_width),
    .pl_period (pl_period),
    .pl_count  (pl_count),
    .pl_mlt    (pl_mlt),
    .PL_out    (PL_out),
    .busy_PL   (busy_PL),
    .End_PL    (End_PL)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: sample n is taken after the n-th posedge following the launch
  // edge. First high sample is S+2; pulses repeat every hi+lo clks.
  function automatic int tick_len(input int m);
    return (m == 2) ? DM : (m == 3) ? DS : 1;
  endfunction

  function automatic int end_idx(input int w, input int p, input int c, input int m);
    int t, hi, lo;
    if (c == 0 || w == 0) return S + 2;
    t  = tick_len(m);
    hi = w * t;
    lo = ((p > w) ? (p - w) : 1) * t;
    return S + 2 + (c - 1) * (hi + lo) + hi;
  endfunction

  function automatic logic [2:0] model(input int n, input int w, input int p, input int c, input int m);
    int t, hi, lo, st, e;
    logic pl;
    st = S + 2;
    e  = end_idx(w, p, c, m);
    pl = 1'b0;
    if (c != 0 && w != 0) begin
      t  = tick_len(m);
      hi = w * t;
      lo = ((p > w) ? (p - w) : 1) * t;
      pl = (n >= st) && (n < e) && (((n - st) % (hi + lo)) < hi);
    end
    return {pl, (n >= st) && (n <= e), n == e};
  endfunction

  // abort_at > 0 drops launch after that edge; everything is zero from
  // abort_at+S+1 on. Inputs are scrambled once the rise has been latched.
  task automatic run(input int w, input int p, input int c, input int m,
                     input int abort_at, input string tag);
    int nmax;
    logic [2:0] e;
    nmax = end_idx(w, p, c, m) + 4;
    @(posedge clk_PL); #1;
    pl_width  = 17'(w);
    pl_period = 17'(p);
    pl_count  = 8'(c);
    pl_mlt    = 5'(m);
    launch_PL = 1'b1;
    for (int n = 1; n <= nmax; n++) begin
      @(posedge clk_PL); #1;
      if (n == abort_at) launch_PL = 1'b0;
      if (n == S + 3) begin
        pl_width  = 17'($urandom_range(0, 9));
        pl_period = 17'($urandom_range(0, 9));
        pl_count  = 8'($urandom_range(0, 9));
        pl_mlt    = 5'($urandom_range(0, 31));
      end
      @(negedge clk_PL);
      e = (abort_at > 0 && n >= abort_at + S + 1) ? 3'b000 : model(n, w, p, c, m);
      chk($sformatf("%s n%0d", tag, n), 32'({PL_out, busy_PL, End_PL}), 32'(e));
    end
  endtask

  task automatic quiet(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_PL);
      chk($sformatf("%s q%0d", tag, i), 32'({PL_out, busy_PL, End_PL}), 32'd0);
    end
  endtask

  task automatic drop(input string tag);
    @(posedge clk_PL); #1;
    launch_PL = 1'b0;
    quiet(S + 4, tag);
  endtask

  initial begin
    int w, p, c, m, r, ab;
    #3;
    chk("reset", 32'({PL_out, busy_PL, End_PL}), 32'd0);
    @(negedge clk_PL); rst_n = 1'b1;
    quiet(3, "idle");

    run(3, 5, 2, 1, 0, "t1");           drop("t1d");
    run(3, 5, 0, 1, 0, "t2cnt0");       drop("t2d");
    run(0, 5, 2, 1, 0, "t2w0");         drop("t2e");
    run(1, 1, 3, 2, 0, "t3mid");        drop("t3d");
    run(6, 8, 4, 1, 4, "t4abort");      drop("t4d");
    run(6, 8, 4, 1, 0, "t4re");         drop("t4e");

    // Held launch after the train: new inputs must not re-trigger.
    run(2, 4, 2, 1, 0, "t5a");
    pl_width = 17'd4; pl_period = 17'd6; pl_count = 8'd2; pl_mlt = 5'd1;
    quiet(40, "t5hold");
    drop("t5d");
    run(4, 6, 2, 1, 0, "t5b");          drop("t5e");

    run(1, 2, 2, 3, 0, "slow");         drop("slowd");

    // Reset asserted mid-LOW (w=3,p=8: low on samples 7..11).
    @(posedge clk_PL); #1;
    pl_width = 17'd3; pl_period = 17'd8; pl_count = 8'd3; pl_mlt = 5'd1;
    launch_PL = 1'b1;
    repeat (8) @(posedge clk_PL);
    #2;
    chk("t6 low", 32'({PL_out, busy_PL, End_PL}), 32'b010);
    rst_n = 1'b0;
    launch_PL = 1'b0;
    #1;
    chk("t6 async", 32'({PL_out, busy_PL, End_PL}), 32'd0);
    @(negedge clk_PL); rst_n = 1'b1;
    quiet(S + 4, "t6idle");
    run(3, 8, 3, 1, 0, "t6re");         drop("t6d");

    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 2) begin
        m = 2;
        w = int'($urandom_range(0, 2));
        p = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 2));
      end else begin
        m = (r < 4) ? int'($urandom_range(4, 31)) : (r < 5) ? 0 : 1;
        w = int'($urandom_range(0, 5));
        p = int'($urandom_range(0, 8));
        c = int'($urandom_range(0, 4));
      end
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 12)) : 0;
      run(w, p, c, m, ab, $sformatf("rnd%0d", k));
      drop($sformatf("rnd%0dd", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
